// File: rtl/ntt_pkg.sv
// ntt_pkg: shared scheduler states, default transform sizes and the radix-2 pair-address function.
package ntt_pkg;
   localparam int N_DEF       = 512;
   localparam int LOGN_DEF    = 9;
   localparam int MEM_LAT_DEF = 1;
   localparam int BF_LAT_DEF  = 2;

   typedef enum logic [2:0] {ST_IDLE, ST_ISSUE, ST_GAP, ST_FLUSH, ST_DONE} state_t;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] tw;
   } pair_t;

   // half is always a power of two, so grp/k reduce to a shift and a mask
   function automatic pair_t pair_addr(input int logn, input int s, input int j, input logic inv);
      int    lh;
      int    grp;
      pair_t p;
      lh   = inv ? s : logn - 1 - s;
      grp  = j >> lh;
      p.a  = (grp << (lh + 1)) + (j & ((1 << lh) - 1));
      p.b  = p.a + (1 << lh);
      p.tw = (1 << (inv ? logn - 1 - s : s)) + grp;
      return p;
   endfunction
endpackage

// File: rtl/ntt_addr_gen.sv
// ntt_addr_gen: combinational (stage, pair, direction) to coefficient pair and twiddle address.
module ntt_addr_gen
   import ntt_pkg::*;
#(
   parameter int LOGN = LOGN_DEF,
   parameter int AW   = LOGN_DEF,
   parameter int SW   = $clog2(LOGN_DEF)
)(
   input  logic [SW-1:0] s,
   input  logic [AW-1:0] j,
   input  logic          inverse,
   output logic [AW-1:0] a,
   output logic [AW-1:0] b,
   output logic [AW-1:0] tw
);
   pair_t w_p;
   assign w_p = pair_addr(LOGN, int'(s), int'(j), inverse);
   assign a   = AW'(w_p.a);
   assign b   = AW'(w_p.b);
   assign tw  = AW'(w_p.tw);
endmodule

// File: rtl/ntt_bf_scheduler.sv
// ntt_bf_scheduler: stage/pair sequencer for the NTT butterfly with aligned write-back addresses.
// NTT_SCHED_STAGE_GAP_EN inserts a drain gap between stages so no stage reads a value still in flight.
module ntt_bf_scheduler
   import ntt_pkg::*;
#(
   parameter int N       = N_DEF,
   parameter int LOGN    = LOGN_DEF,
   parameter int AW      = LOGN_DEF,
   parameter int MEM_LAT = MEM_LAT_DEF,
   parameter int BF_LAT  = BF_LAT_DEF
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          inverse,
   input  logic          hold,
   output logic          rd_en,
   output logic [AW-1:0] rd_addr_a,
   output logic [AW-1:0] rd_addr_b,
   output logic [AW-1:0] tw_addr,
   output logic          bf_valid,
   output logic          bf_mod,
   output logic          wr_en,
   output logic [AW-1:0] wr_addr_a,
   output logic [AW-1:0] wr_addr_b,
   output logic          busy,
   output logic          done
);
   localparam int D = MEM_LAT + BF_LAT;
   localparam int SW = $clog2(LOGN);
   localparam logic [AW-1:0] J_LAST = AW'(N / 2 - 1);
   localparam logic [SW-1:0] S_LAST = SW'(LOGN - 1);

   state_t        r_state;
   logic [SW-1:0] r_s;
   logic [AW-1:0] r_j;
   logic          r_inv;
   logic [D-1:0]  r_v;
   logic [AW-1:0] r_wa [D];
   logic [AW-1:0] r_wb [D];
   logic [AW-1:0] w_a, w_b, w_tw;
   logic          w_issue, w_drained;

   ntt_addr_gen #(.LOGN(LOGN), .AW(AW), .SW(SW)) u_addr_gen (
      .s(r_s), .j(r_j), .inverse(r_inv), .a(w_a), .b(w_b), .tw(w_tw)
   );

   assign w_issue   = (r_state == ST_ISSUE) && !hold;
   // the last delay stage is the write itself, so it retires in the cycle we leave
   assign w_drained = ~|r_v[D-2:0];
   assign rd_en     = w_issue;
   assign rd_addr_a = w_issue ? w_a : '0;
   assign rd_addr_b = w_issue ? w_b : '0;
   assign tw_addr   = w_issue ? w_tw : '0;
   assign bf_valid  = r_v[MEM_LAT-1];
   assign bf_mod    = r_inv;
   assign wr_en     = r_v[D-1];
   assign wr_addr_a = r_wa[D-1];
   assign wr_addr_b = r_wb[D-1];
   assign busy      = (r_state == ST_ISSUE) || (r_state == ST_GAP) || (r_state == ST_FLUSH);
   assign done      = r_state == ST_DONE;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_s     <= '0;
         r_j     <= '0;
         r_inv   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: if (start) begin
               r_inv   <= inverse;
               r_s     <= '0;
               r_j     <= '0;
               r_state <= ST_ISSUE;
            end
            ST_ISSUE: if (!hold) begin
               if (r_j != J_LAST) r_j <= r_j + 1'b1;
               else begin
                  r_j <= '0;
                  if (r_s != S_LAST) begin
                     r_s <= r_s + 1'b1;
`ifdef NTT_SCHED_STAGE_GAP_EN
                     r_state <= ST_GAP;
`else
                     r_state <= ST_ISSUE;
`endif
                  end else r_state <= ST_FLUSH;
               end
            end
            ST_GAP:   if (w_drained) r_state <= ST_ISSUE;
            ST_FLUSH: if (w_drained) r_state <= ST_DONE;
            default:  r_state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_v <= '0;
         for (int i = 0; i < D; i++) begin
            r_wa[i] <= '0;
            r_wb[i] <= '0;
         end
      end else begin
         r_v     <= {r_v[D-2:0], w_issue};
         r_wa[0] <= rd_addr_a;
         r_wb[0] <= rd_addr_b;
         for (int i = 1; i < D; i++) begin
            r_wa[i] <= r_wa[i-1];
            r_wb[i] <= r_wb[i-1];
         end
      end
   end
endmodule

// File: tb/tb_ntt_bf_scheduler.sv
// tb_ntt_bf_scheduler: scoreboard bench for an 8-point scheduler; follows NTT_SCHED_STAGE_GAP_EN.
module tb_ntt_bf_scheduler;
   localparam int N = 8;
   localparam int LOGN = 3;
   localparam int AW = 3;
   localparam int D = 3;
   localparam int TOTAL = LOGN * N / 2;
`ifdef NTT_SCHED_STAGE_GAP_EN
   localparam int GAP = 3;
`else
   localparam int GAP = 0;
`endif

   logic          clk = 1'b0;
   logic          rst, start, inverse, hold;
   logic          rd_en, bf_valid, bf_mod, wr_en, busy, done;
   logic [AW-1:0] rd_addr_a, rd_addr_b, tw_addr, wr_addr_a, wr_addr_b;

   int         errors = 0;
   int         checks = 0;
   logic [8:0] rdq [$];
   logic [5:0] wrq [$];
   logic [8:0] obs [16];
   int         nobs;

   always #5 clk = ~clk;

   ntt_bf_scheduler #(.N(N), .LOGN(LOGN), .AW(AW)) dut (
      .clk(clk), .rst(rst), .start(start), .inverse(inverse), .hold(hold),
      .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .tw_addr(tw_addr),
      .bf_valid(bf_valid), .bf_mod(bf_mod), .wr_en(wr_en),
      .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b), .busy(busy), .done(done)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic [8:0] pk(input int a, input int b, input int t);
      return {a[2:0], b[2:0], t[2:0]};
   endfunction

   function automatic logic [8:0] exp_pair(input int s, input int j, input logic inv);
      int half, grp, a;
      half = inv ? (1 << s) : (N >> (s + 1));
      grp  = j / half;
      a    = grp * 2 * half + j % half;
      return pk(a, a + half, inv ? (N >> (s + 1)) + grp : (1 << s) + grp);
   endfunction

   function automatic logic [31:0] all_out();
      return 32'({rd_en, rd_addr_a, rd_addr_b, tw_addr, bf_valid, bf_mod, wr_en,
                  wr_addr_a, wr_addr_b, busy, done});
   endfunction

   task automatic run(input logic inv, input int h0, input int h1, input int restart, input int abort_at);
      int         e, issued, gapc;
      logic       er;
      logic [D:0] eh;
      logic [8:0] p;
      e = TOTAL + (LOGN - 1) * GAP + (h1 - h0 + 1) + 4;
      issued = 0;
      gapc = 0;
      eh = '0;
      nobs = 0;
      rdq.delete();
      wrq.delete();
      for (int s = 0; s < LOGN; s++)
         for (int j = 0; j < N / 2; j++) rdq.push_back(exp_pair(s, j, inv));
      @(negedge clk);
      inverse = inv;
      start = 1'b1;
      hold = 1'b0;
      @(posedge clk);
      for (int c = 1; c <= e; c++) begin
         #1;
         start = (c == restart);
         hold = (c >= h0) && (c <= h1);
         if (c == abort_at) begin
            rst = 1'b1;
            #1 check("abort_outs_now", all_out(), 0);
            @(negedge clk) check("abort_outs_hold", all_out(), 0);
            @(posedge clk) #1 rst = 1'b0;
            @(negedge clk) check("abort_no_write", all_out(), 0);
            return;
         end
         @(negedge clk);
         if (gapc > 0) begin
            er = 1'b0;
            gapc--;
         end else if (issued < TOTAL && !hold) begin
            er = 1'b1;
            issued++;
            if (issued % (N / 2) == 0 && issued < TOTAL) gapc = GAP;
         end else er = 1'b0;
         eh = {eh[D-1:0], er};
         check("rd_en", 32'(rd_en), 32'(er));
         if (rd_en) begin
            if (rdq.size() == 0) check("rd_extra", 1, 0);
            else begin
               p = rdq.pop_front();
               check("rd_pair", 32'({rd_addr_a, rd_addr_b, tw_addr}), 32'(p));
               wrq.push_back(p[8:3]);
               if (nobs < 16) obs[nobs] = {rd_addr_a, rd_addr_b, tw_addr};
               nobs++;
            end
         end
         check("bf_valid", 32'(bf_valid), 32'(eh[1]));
         check("wr_en", 32'(wr_en), 32'(eh[D]));
         if (wr_en) begin
            if (wrq.size() == 0) check("wr_extra", 1, 0);
            else check("wr_pair", 32'({wr_addr_a, wr_addr_b}), 32'(wrq.pop_front()));
         end
         check("busy", 32'(busy), 32'(c < e));
         check("done", 32'(done), 32'(c == e));
         if (c < e) check("bf_mod", 32'(bf_mod), 32'(inv));
         @(posedge clk);
      end
      @(negedge clk);
      check("done_single", 32'({busy, done}), 0);
      check("rd_left", rdq.size(), 0);
      check("wr_left", wrq.size(), 0);
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0;
      hold = 1'b0;
      inverse = 1'b0;
      repeat (2) @(posedge clk);
      #1 check("reset_outs", all_out(), 0);
      @(negedge clk) rst = 1'b0;
      @(negedge clk) check("idle_outs", all_out(), 0);

      run(1'b0, 0, -1, 0, 0);
      for (int j = 0; j < 4; j++) check("fwd_stage0_lit", 32'(obs[j]), 32'(pk(j, j + 4, 1)));
      check("fwd_stage1_lit0", 32'(obs[4]), 32'(pk(0, 2, 2)));
      check("fwd_stage1_lit1", 32'(obs[5]), 32'(pk(1, 3, 2)));
      check("fwd_stage1_lit2", 32'(obs[6]), 32'(pk(4, 6, 3)));
      check("fwd_stage1_lit3", 32'(obs[7]), 32'(pk(5, 7, 3)));

      run(1'b1, 0, -1, 0, 0);
      for (int j = 0; j < 4; j++) begin
         check("inv_stage0_lit", 32'(obs[j]), 32'(pk(2 * j, 2 * j + 1, 4 + j)));
         check("inv_last_lit", 32'(obs[8 + j]), 32'(pk(j, j + 4, 1)));
      end

      run(1'b0, 2, 4, 0, 0);
      run(1'b0, 0, -1, 5, 0);
      run(1'b1, 0, -1, 0, 6);
      run(1'b1, 0, -1, 0, 0);
      run(1'b1, 3, 3, 7, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
